// File: rtl/prng_lfsr_param_if.sv
// Control/data bundle between the chip io wrapper (master) and the PRNG core (slave).
// The wrapper supplies the seed and requests; the core returns the latest word and its status.
interface prng_lfsr_param_if #(
  parameter int WIDTH = 8
);
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             en;
  logic             free_run;
  logic [WIDTH-1:0] rand_num;
  logic             valid;
  logic             busy;

  modport master (
    output seed_load, seed, en, free_run,
    input  rand_num, valid, busy
  );

  modport slave (
    input  seed_load, seed, en, free_run,
    output rand_num, valid, busy
  );
endinterface

// File: rtl/prng_lfsr_param.sv
// Galois-LFSR pseudo-random word generator with a configurable number of whitening steps per word.
// Provides single-shot and free-running modes, a zero-seed guard and abort-on-reseed.
module prng_lfsr_param #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'hB8),
  parameter int               STEPS        = 4,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic              clock,
  input  logic              reset_n,
  prng_lfsr_param_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter index of the final step of a word; STEPS is limited to 1..15.
  localparam logic [3:0] LAST_CNT = 4'(STEPS - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] rand_q, rand_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] lfsr_stepped;
  logic [WIDTH-1:0] seed_safe;

  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ TAPS;
    end
    return r;
  endfunction

  assign lfsr_stepped = galois_step(lfsr_q);
  // An all-zero state would lock the LFSR forever, so zero seeds are replaced.
  assign seed_safe    = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    rand_d  = rand_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.seed_load) begin
          lfsr_d = seed_safe;
        end else if (bus.en || bus.free_run) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end

      RUN: begin
        if (bus.seed_load) begin
          lfsr_d  = seed_safe;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          lfsr_d = lfsr_stepped;
          if (cnt_q == LAST_CNT) begin
            rand_d  = lfsr_stepped;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = bus.free_run ? RUN : IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= DEFAULT_SEED;
      rand_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
    end
  end

  assign bus.rand_num = rand_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q == RUN);

endmodule

// File: tb/tb_prng_lfsr_param.sv
// Directed bench for prng_lfsr_param: an 8-bit/4-step instance for the main scenarios
// and an 8-bit/1-step instance for the minimum whitening depth.
module tb_prng_lfsr_param;

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  prng_lfsr_param_if #(.WIDTH(8)) if8 ();
  prng_lfsr_param_if #(.WIDTH(8)) if1 ();

  prng_lfsr_param #(
    .WIDTH(8), .TAPS(8'hB8), .STEPS(4), .DEFAULT_SEED(8'h01)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (if8)
  );

  prng_lfsr_param #(
    .WIDTH(8), .TAPS(8'hB8), .STEPS(1), .DEFAULT_SEED(8'h01)
  ) dut_s1 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (if1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_seed(input logic [7:0] v);
    if8.seed_load = 1'b1;
    if8.seed      = v;
    tick();
    if8.seed_load = 1'b0;
    check("seed_valid", 32'(if8.valid), 32'd0);
    check("seed_busy",  32'(if8.busy),  32'd0);
  endtask

  // One en pulse; valid must appear exactly after the fourth RUN edge.
  task automatic single_word(input string tag, input logic [7:0] exp);
    if8.en = 1'b1;
    tick();
    if8.en = 1'b0;
    check({tag, "_busy_start"}, 32'(if8.busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) begin
        check({tag, "_early_valid"}, 32'(if8.valid), 32'd0);
      end else begin
        check({tag, "_valid"}, 32'(if8.valid),    32'd1);
        check({tag, "_word"},  32'(if8.rand_num), 32'(exp));
        check({tag, "_busy_end"}, 32'(if8.busy),  32'd0);
      end
    end
    tick();
    check({tag, "_valid_pulse"}, 32'(if8.valid),    32'd0);
    check({tag, "_hold"},        32'(if8.rand_num), 32'(exp));
  endtask

  logic [7:0] fr_words [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    fr_words[0] = 8'hE8;
    fr_words[1] = 8'hB6;
    fr_words[2] = 8'h79;
    fr_words[3] = 8'hA8;

    if8.seed_load = 1'b0; if8.seed = '0; if8.en = 1'b0; if8.free_run = 1'b0;
    if1.seed_load = 1'b0; if1.seed = '0; if1.en = 1'b0; if1.free_run = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_rand",  32'(if8.rand_num), 32'h0);
    check("rst_valid", 32'(if8.valid),    32'd0);
    check("rst_busy",  32'(if8.busy),     32'd0);
    reset_n = 1'b1;
    tick();

    // Seeded single shots, including hold between words
    do_seed(8'hCC);
    single_word("t1", 8'hE8);
    repeat (3) tick();
    check("t1_idle_hold", 32'(if8.rand_num), 32'hE8);
    single_word("t2", 8'hB6);

    // Zero seed falls back to DEFAULT_SEED
    do_seed(8'h00);
    single_word("t3", 8'h17);

    // Free-running: back-to-back words, then completion after free_run drops
    do_seed(8'hCC);
    if8.free_run = 1'b1;
    tick();
    for (int w = 0; w < 4; w++) begin
      if (w == 3) if8.free_run = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        tick();
        check("t4_valid", 32'(if8.valid), (i == 4) ? 32'd1 : 32'd0);
        if (i == 4) begin
          check("t4_word", 32'(if8.rand_num), 32'(fr_words[w]));
          check("t4_busy_last", 32'(if8.busy), (w == 3) ? 32'd0 : 32'd1);
        end else begin
          check("t4_busy", 32'(if8.busy), 32'd1);
        end
      end
    end
    tick();
    check("t4_idle_valid", 32'(if8.valid), 32'd0);
    check("t4_idle_busy",  32'(if8.busy),  32'd0);

    // Reseed two cycles into RUN aborts the word
    do_seed(8'hCC);
    if8.en = 1'b1;
    tick();
    if8.en = 1'b0;
    tick();
    tick();
    if8.seed_load = 1'b1;
    if8.seed      = 8'hCC;
    tick();
    if8.seed_load = 1'b0;
    check("t5_abort_valid", 32'(if8.valid),    32'd0);
    check("t5_abort_busy",  32'(if8.busy),     32'd0);
    check("t5_abort_rand",  32'(if8.rand_num), 32'hA8);
    tick();
    check("t5_idle_valid", 32'(if8.valid), 32'd0);
    single_word("t5", 8'hE8);

    // Asynchronous reset mid-RUN
    if8.en = 1'b1;
    tick();
    if8.en = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_rand",  32'(if8.rand_num), 32'h0);
    check("t6_rst_valid", 32'(if8.valid),    32'd0);
    check("t6_rst_busy",  32'(if8.busy),     32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    single_word("t6_post", 8'h17);

    // STEPS=1: one step per word, valid right after the first RUN edge
    if1.seed_load = 1'b1;
    if1.seed      = 8'hCC;
    tick();
    if1.seed_load = 1'b0;
    if1.en        = 1'b1;
    tick();
    if1.en = 1'b0;
    check("s1_busy",  32'(if1.busy),  32'd1);
    check("s1_early", 32'(if1.valid), 32'd0);
    tick();
    check("s1_valid",    32'(if1.valid),    32'd1);
    check("s1_word",     32'(if1.rand_num), 32'h66);
    check("s1_busy_end", 32'(if1.busy),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
